load_store_unit: RTL

Memory-stage load/store unit sitting directly downstream of the ALU. Takes the ALU result as effective address and rs2 as store data, runs one word-aligned bus transaction per request through a valid/ready-then-req/ack handshake, and returns sign- or zero-extended load data with its destination register to writeback. Stalls the pipeline from acceptance until completion.

---
 rtl/load_store_unit.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage LSU, one word-aligned bus access per request.
// `define LSU_MISALIGN_TRAP_EN to reject misaligned accesses instead of aligning them.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_idx,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        st_done,
  output logic        misaligned,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic        idle;
  logic        accept;
  logic        issue;
  logic        is_byte;
  logic        is_half;
  logic [1:0]  off;
  logic [3:0]  be_nx;
  logic [31:0] wdata_nx;

  logic        we_q;
  logic        byte_q;
  logic        half_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic [29:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] wb_data_q;
  logic [4:0]  wb_rd_q;

  logic [31:0] rsh;
  logic [31:0] ld_ext;

  assign idle   = (state == IDLE);
  assign accept = req_valid & idle & (mem_read ^ mem_write);

  // Access size: LBU/LHU codes only exist for loads
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    unique case (1'b1)
      (funct3 == 3'b000),
      (mem_read && funct3 == 3'b100): is_byte = 1'b1;
      (funct3 == 3'b001),
      (mem_read && funct3 == 3'b101): is_half = 1'b1;
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_req;
  logic mis_q;

  assign mis_req = (is_half & addr[0]) |
                   (~is_byte & ~is_half & (addr[1:0] != 2'b00));
  assign issue   = accept & ~mis_req;

  // One-cycle reject pulse after a misaligned request is consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= accept & mis_req;
  end

  assign misaligned = mis_q;
`else
  assign issue      = accept;
  assign misaligned = 1'b0;
`endif

  // Lane offset with low bits forced aligned, plus lane enables and data
  always_comb begin
    off      = 2'b00;
    be_nx    = 4'b1111;
    wdata_nx = store_data;
    unique case (1'b1)
      is_byte: begin
        off      = addr[1:0];
        wdata_nx = {4{store_data[7:0]}};
      end
      is_half: begin
        off      = {addr[1], 1'b0};
        wdata_nx = {2{store_data[15:0]}};
      end
      default: ;
    endcase
    if (mem_write) begin
      unique case (1'b1)
        is_byte: be_nx = 4'b0001 << off;
        is_half: be_nx = 4'b0011 << off;
        default: be_nx = 4'b1111;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (issue) state_nx = BUS;
      BUS:     if (bus_ack) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake and pulse outputs decoded from state
  always_comb begin
    req_ready = 1'b0;
    stall     = 1'b0;
    bus_req   = 1'b0;
    wb_valid  = 1'b0;
    st_done   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = accept;
      end
      BUS: begin
        bus_req = 1'b1;
        stall   = 1'b1;
      end
      RESP: begin
        wb_valid = ~we_q;
        st_done  = we_q;
      end
      default: ;
    endcase
  end

  // Request latch; bus outputs are driven from here so they stay stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      half_q  <= 1'b0;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      rd_q    <= 5'd0;
      addr_q  <= 30'd0;
      be_q    <= 4'b0000;
      wdata_q <= 32'd0;
    end else if (issue) begin
      we_q    <= mem_write;
      byte_q  <= is_byte;
      half_q  <= is_half;
      uns_q   <= funct3[2];
      off_q   <= off;
      rd_q    <= rd_idx;
      addr_q  <= addr[31:2];
      be_q    <= be_nx;
      wdata_q <= wdata_nx;
    end
  end

  // Lane extraction and sign/zero extension of read data
  always_comb begin
    rsh    = bus_rdata >> {off_q, 3'b000};
    ld_ext = bus_rdata;
    unique case (1'b1)
      byte_q:  ld_ext = {{24{~uns_q & rsh[7]}}, rsh[7:0]};
      half_q:  ld_ext = {{16{~uns_q & rsh[15]}}, rsh[15:0]};
      default: ld_ext = bus_rdata;
    endcase
  end

  // Writeback data holds until the next load completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_data_q <= 32'd0;
      wb_rd_q   <= 5'd0;
    end else if (state == BUS && bus_ack && !we_q) begin
      wb_data_q <= ld_ext;
      wb_rd_q   <= rd_q;
    end
  end

  assign bus_we    = we_q;
  assign bus_addr  = {addr_q, 2'b00};
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign wb_data   = wb_data_q;
  assign wb_rd     = wb_rd_q;

endmodule
